// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle: operands and opcode in, status and results out.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_neg;
    logic             flag_ovf;
    logic             flag_dz;
    logic             illegal;

    modport master (
        output start, opcode, operand1, operand2,
        input  busy, done, result, result_hi,
        input  flag_zero, flag_carry, flag_neg, flag_ovf, flag_dz, illegal
    );

    modport slave (
        input  start, opcode, operand1, operand2,
        output busy, done, result, result_hi,
        output flag_zero, flag_carry, flag_neg, flag_ovf, flag_dz, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle 16-opcode ALU: single-cycle ops, iterative shift-add MUL, restoring DIV.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode 3 reports illegal.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, carry_q, neg_q, ovf_q, dz_q, ill_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] s_res, s_hi;
    logic             s_carry, s_ovf, s_dz, s_ill;
    logic [WIDTH:0]   add_w, sub_w;

    assign a = bus.operand1;
    assign b = bus.operand2;

    always_comb begin
        s_res   = '0;
        s_hi    = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dz    = 1'b0;
        s_ill   = 1'b0;
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        unique case (bus.opcode)
            OP_ADD: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
                s_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: s_res = '0;
            OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                // Only reached with B=0; nonzero divisors take the iterative path.
                s_res = '1;
                s_hi  = a;
                s_dz  = 1'b1;
`else
                s_ill = 1'b1;
`endif
            end
            OP_SHL: begin
                s_res   = {a[WIDTH-2:0], 1'b0};
                s_carry = a[WIDTH-1];
            end
            OP_SHR: begin
                s_res   = {1'b0, a[WIDTH-1:1]};
                s_carry = a[0];
            end
            OP_ROL: begin
                s_res   = {a[WIDTH-2:0], a[WIDTH-1]};
                s_carry = a[WIDTH-1];
            end
            OP_ROR: begin
                s_res   = {a[0], a[WIDTH-1:1]};
                s_carry = a[0];
            end
            OP_AND:  s_res = a & b;
            OP_OR:   s_res = a | b;
            OP_XOR:  s_res = a ^ b;
            OP_NOR:  s_res = ~(a | b);
            OP_NAND: s_res = ~(a & b);
            OP_XNOR: s_res = ~(a ^ b);
            OP_GT:   s_res = WIDTH'(a > b);
            OP_EQ:   s_res = WIDTH'(a == b);
            default: s_res = '0;
        endcase
    end

    // Shift-add step: {hi,lo} holds partial product above the unconsumed multiplier bits.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;

    always_comb begin
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd_q};
        if (!trial[WIDTH]) begin
            div_hi_n = trial[WIDTH-1:0];
            div_lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_n = rem_sh[WIDTH-1:0];
            div_lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.opcode == OP_MUL) begin
                            state_q <= S_MUL;
                            cnt_q   <= CW'(WIDTH);
                            hi_q    <= '0;
                            lo_q    <= b;
                            opnd_q  <= a;
                            busy_q  <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
                        end else if (bus.opcode == OP_DIV && b != '0) begin
                            state_q <= S_DIV;
                            cnt_q   <= CW'(WIDTH);
                            hi_q    <= '0;
                            lo_q    <= a;
                            opnd_q  <= b;
                            busy_q  <= 1'b1;
`endif
                        end else begin
                            result_q    <= s_res;
                            result_hi_q <= s_hi;
                            zero_q      <= (s_res == '0);
                            neg_q       <= s_res[WIDTH-1];
                            carry_q     <= s_carry;
                            ovf_q       <= s_ovf;
                            dz_q        <= s_dz;
                            ill_q       <= s_ill;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= mul_lo_n;
                        result_hi_q <= mul_hi_n;
                        zero_q      <= (mul_lo_n == '0);
                        neg_q       <= mul_lo_n[WIDTH-1];
                        carry_q     <= 1'b0;
                        ovf_q       <= (mul_hi_n != '0);
                        dz_q        <= 1'b0;
                        ill_q       <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    hi_q  <= div_hi_n;
                    lo_q  <= div_lo_n;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= div_lo_n;
                        result_hi_q <= div_hi_n;
                        zero_q      <= (div_lo_n == '0);
                        neg_q       <= div_lo_n[WIDTH-1];
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        dz_q        <= 1'b0;
                        ill_q       <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.result_hi  = result_hi_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_neg   = neg_q;
    assign bus.flag_ovf   = ovf_q;
    assign bus.flag_dz    = dz_q;
    assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=16): arithmetic reference model, decoupled monitor.
module tb_seq_alu;
    localparam int unsigned W = 16;
    localparam longint unsigned MASK = 64'hFFFF;

    typedef struct {
        longint unsigned res;
        longint unsigned hi;
        bit              z, c, n, o, dz, ill;
        int unsigned     lat;
        int unsigned     done_cyc;
        string           name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned busy_from = 0;
    int unsigned busy_to = 0;
    int unsigned next_free = 0;
    bit          chk_en = 1'b0;
    exp_t        q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic longint sgn(input longint unsigned v);
        return (v >= 32768) ? longint'(v) - 65536 : longint'(v);
    endfunction

    function automatic exp_t model(input logic [3:0] op, input longint unsigned a, input longint unsigned b);
        exp_t e;
        longint unsigned r;
        longint sr;
        e.res = 0; e.hi = 0; e.c = 0; e.o = 0; e.dz = 0; e.ill = 0; e.lat = 0;
        e.done_cyc = 0; e.name = "";
        case (op)
            4'h0: begin
                r = a + b; e.res = r & MASK; e.c = (r > MASK);
                sr = sgn(a) + sgn(b); e.o = (sr > 32767) || (sr < -32768);
            end
            4'h1: begin
                e.res = (a - b) & MASK; e.c = (a < b);
                sr = sgn(a) - sgn(b); e.o = (sr > 32767) || (sr < -32768);
            end
            4'h2: begin
                r = a * b; e.res = r & MASK; e.hi = r >> 16; e.o = (e.hi != 0); e.lat = W;
            end
            4'h3: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == 0) begin
                    e.res = MASK; e.hi = a; e.dz = 1;
                end else begin
                    e.res = a / b; e.hi = a % b; e.lat = W;
                end
`else
                e.ill = 1;
`endif
            end
            4'h4: begin e.res = (a << 1) & MASK; e.c = (a >= 32768); end
            4'h5: begin e.res = a >> 1; e.c = (a % 2 == 1); end
            4'h6: begin e.res = ((a << 1) | (a >> 15)) & MASK; e.c = (a >= 32768); end
            4'h7: begin e.res = (a >> 1) | ((a % 2) << 15); e.c = (a % 2 == 1); end
            4'h8: e.res = a & b;
            4'h9: e.res = a | b;
            4'hA: e.res = a ^ b;
            4'hB: e.res = ~(a | b) & MASK;
            4'hC: e.res = ~(a & b) & MASK;
            4'hD: e.res = ~(a ^ b) & MASK;
            4'hE: e.res = (a > b) ? 1 : 0;
            default: e.res = (a == b) ? 1 : 0;
        endcase
        e.z = (e.res == 0);
        e.n = (e.res >= 32768);
        return e;
    endfunction

    // Monitor: busy profile every cycle, scoreboard pop on every done.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("busy", bus.busy, (cyc >= busy_from && cyc < busy_to) ? 1 : 0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check({e.name, ".done_cycle"}, cyc, e.done_cyc);
                    check({e.name, ".result"}, bus.result, e.res);
                    check({e.name, ".result_hi"}, bus.result_hi, e.hi);
                    check({e.name, ".flags_zcnod_ill"},
                          {bus.flag_zero, bus.flag_carry, bus.flag_neg, bus.flag_ovf, bus.flag_dz, bus.illegal},
                          {e.z, e.c, e.n, e.o, e.dz, e.ill});
                end
            end else if (q.size() > 0 && cyc > q[0].done_cyc) begin
                e = q.pop_front();
                check({e.name, ".missing_done"}, 0, 1);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input string nm);
        exp_t e;
        while (cyc + 1 < next_free) @(negedge clk);
        bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.start = 1'b1;
        e = model(op, a, b);
        e.name = nm;
        e.done_cyc = cyc + 1 + e.lat;
        q.push_back(e);
        if (e.lat > 0) begin
            busy_from = cyc + 1;
            busy_to   = cyc + 1 + e.lat;
        end
        next_free = cyc + 2 + e.lat;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Start pulse while the model says the DUT is mid-operation; must be ignored.
    task automatic poke(input logic [15:0] a, input logic [15:0] b);
        if (cyc >= busy_from && cyc + 1 <= busy_to) begin
            bus.opcode = 4'h0; bus.operand1 = a; bus.operand2 = b; bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".result"}, bus.result, 0);
        check({nm, ".result_hi"}, bus.result_hi, 0);
        check({nm, ".ctl_flags"},
              {bus.busy, bus.done, bus.flag_zero, bus.flag_carry, bus.flag_neg, bus.flag_ovf, bus.flag_dz, bus.illegal},
              0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        int unsigned sel, waited;
        bus.start = 1'b0; bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        next_free = cyc + 1;
        chk_en = 1'b1;

        issue(4'h0, 16'hFFFF, 16'h0001, "add_wrap");
        issue(4'h1, 16'h8000, 16'h0001, "sub_ovf");
        issue(4'h6, 16'h8001, 16'h0000, "rol");
        issue(4'h2, 16'h1234, 16'h0100, "mul");
        repeat (3) @(negedge clk);
        poke(16'h0002, 16'h0003);
        issue(4'h3, 16'd100, 16'd7, "div_100_7");
        issue(4'h3, 16'h0042, 16'h0000, "div_by_zero");
        issue(4'hF, 16'd5, 16'd5, "eq");
        issue(4'hE, 16'd3, 16'd9, "gt");

        // Reset in the middle of a multiply: no done, outputs cleared.
        issue(4'h2, 16'hABCD, 16'h1357, "mul_aborted");
        repeat (4) @(negedge clk);
        reset = 1'b1;
        busy_to = cyc + 1;
        next_free = cyc + 2;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("mid_reset");
        issue(4'h0, 16'd2, 16'd3, "add_after_reset");

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h8000 : 16'($urandom);
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h7FFF : 16'($urandom);
            issue(op, a, b, $sformatf("rnd%0d_op%0h", i, op));
            if ($urandom_range(0, 3) == 0) poke(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        waited = 0;
        while (q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
